// File: rtl/matrix_transposer_pp.sv
// rtl/matrix_transposer_pp.sv - ping-pong NxN matrix transposer, row in / column out
//
// Purpose: accepts one matrix row per upstream handshake into the filling
// bank and emits one column per downstream handshake from the draining bank.
// Two banks alternate so a steady stream moves one beat per cycle each side.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   up_data   one row, element j in bits [j*W +: W]
//   up_valid  row valid
//   up_ready  row accepted when up_valid && up_ready
//   dn_data   one column, element r in bits [r*W +: W]; 0 when dn_valid=0
//   dn_valid  column valid
//   dn_ready  column consumed when dn_valid && dn_ready
//   dn_last   high with the final column of a matrix
//   bypass    (MTX_BYPASS_EN only) sampled on row 0; frame passes rows through
//
// Optional feature macro: MTX_BYPASS_EN

module matrix_transposer_pp #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] up_data,
    input  logic           up_valid,
    output logic           up_ready,
    output logic [N*W-1:0] dn_data,
    output logic           dn_valid,
    input  logic           dn_ready,
    output logic           dn_last
`ifdef MTX_BYPASS_EN
    ,
    input  logic           bypass
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Matrix storage; contents are don't-care until a full frame lands.
    logic [N*W-1:0] mem [2][N];

    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [1:0]    full;
    logic [1:0]    full_next;

    logic up_fire;
    logic dn_fire;
    logic up_end;
    logic dn_end;

    logic [N*W-1:0] col_word;

    assign up_ready = !rst && !full[wr_bank];
    assign dn_valid = full[rd_bank];
    assign up_fire  = up_valid && up_ready;
    assign dn_fire  = dn_valid && dn_ready;
    assign up_end   = up_fire && (row_cnt == LAST);
    assign dn_end   = dn_fire && (col_cnt == LAST);
    assign dn_last  = dn_valid && (col_cnt == LAST);

    // A set needs full[wr_bank]=0 and a clear needs full[rd_bank]=1, so a
    // simultaneous set and clear always hit different banks.
    always_comb begin
        full_next = full;
        if (up_end) full_next[wr_bank] = 1'b1;
        if (dn_end) full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            row_cnt <= '0;
            col_cnt <= '0;
            full    <= 2'b00;
        end else begin
            full <= full_next;
            if (up_fire) begin
                row_cnt <= up_end ? '0 : row_cnt + 1'b1;
                if (up_end) wr_bank <= !wr_bank;
            end
            if (dn_fire) begin
                col_cnt <= dn_end ? '0 : col_cnt + 1'b1;
                if (dn_end) rd_bank <= !rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (up_fire) mem[wr_bank][row_cnt] <= up_data;
    end

    // Column col_cnt gathered from every row of the draining bank.
    always_comb begin
        col_word = '0;
        for (int r = 0; r < N; r++) begin
            col_word[r*W +: W] = mem[rd_bank][r][int'(col_cnt)*W +: W];
        end
    end

`ifdef MTX_BYPASS_EN
    logic [1:0] bank_bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_bypass <= 2'b00;
        end else if (up_fire && (row_cnt == '0)) begin
            bank_bypass[wr_bank] <= bypass;
        end
    end

    always_comb begin
        dn_data = '0;
        if (dn_valid) dn_data = bank_bypass[rd_bank] ? mem[rd_bank][col_cnt] : col_word;
    end
`else
    always_comb begin
        dn_data = '0;
        if (dn_valid) dn_data = col_word;
    end
`endif

endmodule
